// File: rtl/ex_divider_pkg.sv
// Shared definitions for the EX-stage iterative divider: op and state
// encodings, fixed special-case results and small op-decoding helpers.
package ex_divider_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // Quotient returned for a zero divisor, and the most-negative value that
    // is both the overflowing dividend and the overflow quotient.
    localparam logic [DIV_XLEN-1:0] DIV_ZERO_Q = '1;
    localparam logic [DIV_XLEN-1:0] DIV_OVF_Q  = {1'b1, {(DIV_XLEN-1){1'b0}}};

    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/ex_divider_if.sv
// Handshake and data bundle between the EX stage (master) and the divider
// (slave). The clock and reset stay plain ports on the divider.
interface ex_divider_if
    import ex_divider_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
);

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_reg;
    logic [XLEN-1:0] rs2_reg;
    logic [4:0]      rd_in;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, op, rs1_reg, rs2_reg, rd_in, flush,
        input  stall, busy, done, result, rd_out
    );

    modport slave (
        input  start, op, rs1_reg, rs2_reg, rd_in, flush,
        output stall, busy, done, result, rd_out
    );

endinterface

// File: rtl/ex_div_core.sv
// Unsigned restoring division datapath: one quotient bit per step. The
// caller loads magnitudes, pulses step once per cycle and reads the
// post-step quotient/remainder combinationally on the last step.
module ex_div_core
    import ex_divider_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next,
    output logic            last_step
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    trial;
    logic             fits;

    // One restoring step. Because rem < divisor always holds, the
    // difference fits in XLEN+1 bits and its MSB is a valid sign.
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        trial     = shifted - {1'b0, dvs_q};
        fits      = ~trial[XLEN];
        rem_next  = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], fits};
        last_step = (cnt_q == LAST_CNT);
    end

    // Next-state for the datapath registers: load wins over step.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
        end else if (step) begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_divider.sv
// RV32M divide unit for the EX stage. Owns the IDLE/CALC/DONE sequencing,
// operand sign handling, divide-by-zero and overflow shortcuts, flush and
// the pipeline stall; the bit-serial iteration lives in ex_div_core.
module ex_divider
    import ex_divider_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic        clk,
    input  logic        rst_n,
    ex_divider_if.slave bus
);

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    div_op_e         op_in;
    logic [4:0]      rd_tag_q, rd_tag_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic            in_signed;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN-1:0] rs1_abs;
    logic [XLEN-1:0] rs2_abs;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;

    logic            core_load;
    logic            core_step;
    logic [XLEN-1:0] core_quo;
    logic [XLEN-1:0] core_rem;
    logic            core_last;

    // Decode the incoming op: magnitudes, shortcut detection and the
    // shortcut result, all from the forwarded operands.
    always_comb begin
        op_in     = div_op_e'(bus.op);
        accept    = (state_q == ST_IDLE) && bus.start && !bus.flush;
        in_signed = op_is_signed(op_in);
        rs1_abs   = (in_signed && bus.rs1_reg[XLEN-1]) ? -bus.rs1_reg : bus.rs1_reg;
        rs2_abs   = (in_signed && bus.rs2_reg[XLEN-1]) ? -bus.rs2_reg : bus.rs2_reg;
        div_zero  = (bus.rs2_reg == '0);
        sgn_ovf   = in_signed && (bus.rs1_reg == DIV_OVF_Q) && (bus.rs2_reg == DIV_ZERO_Q);
        if (op_is_rem(op_in)) begin
            special_res = div_zero ? bus.rs1_reg : '0;
        end else begin
            special_res = div_zero ? DIV_ZERO_Q : DIV_OVF_Q;
        end
    end

    // Apply the recorded signs to the final unsigned step outputs.
    always_comb begin
        quo_fin = q_neg_q ? -core_quo : core_quo;
        rem_fin = r_neg_q ? -core_rem : core_rem;
    end

    // Sequencing: flush overrides everything; results are captured on
    // the transition into DONE so done and result line up.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_tag_d  = rd_tag_q;
        rd_out_d  = rd_out_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        done_d    = 1'b0;
        result_d  = result_q;
        core_load = 1'b0;
        core_step = 1'b0;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_d     = op_in;
                        rd_tag_d = bus.rd_in;
                        q_neg_d  = in_signed && (bus.rs1_reg[XLEN-1] ^ bus.rs2_reg[XLEN-1]);
                        r_neg_d  = in_signed && bus.rs1_reg[XLEN-1];
                        if (div_zero || sgn_ovf) begin
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            result_d = special_res;
                            rd_out_d = bus.rd_in;
                        end else begin
                            state_d   = ST_CALC;
                            core_load = 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        result_d = op_is_rem(op_q) ? rem_fin : quo_fin;
                        rd_out_d = rd_tag_q;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= DIV_OP_DIV;
            rd_tag_q <= '0;
            rd_out_q <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_tag_q <= rd_tag_d;
            rd_out_q <= rd_out_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    ex_div_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .dividend (rs1_abs),
        .divisor  (rs2_abs),
        .quo_next (core_quo),
        .rem_next (core_rem),
        .last_step(core_last)
    );

    assign bus.stall  = accept || (state_q == ST_CALC);
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: directed cases plus random ops,
// compared against an arithmetic reference of RV32M division.
module tb_ex_divider;
    import ex_divider_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   nChecks = 0;
    int   nPass   = 0;

    ex_divider_if bus();

    ex_divider dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] opv, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        bus.start   = s;
        bus.op      = opv;
        bus.rs1_reg = a;
        bus.rs2_reg = b;
        bus.rd_in   = rd;
    endtask

    // RV32M semantics from plain arithmetic; latency 1 for shortcuts, else 33.
    task automatic refModel(input logic [1:0] opv, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output int lat);
        logic [31:0] q;
        logic [31:0] r;
        bit          sgn;
        sgn = (opv == DIV_OP_DIV) || (opv == DIV_OP_REM);
        lat = 33;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; lat = 1;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        res = opv[1] ? r : q;
    endtask

    // Runs one op starting in the current cycle (called just after a rising
    // edge, with the divider idle). glitchCyc >= 0 drives different inputs
    // for that one cycle while the op is in flight.
    task automatic runOp(input string tag, input logic [1:0] opv, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int glitchCyc);
        logic [31:0] expRes;
        int          expLat;
        int          doneCyc;
        int          stallCnt;
        refModel(opv, a, b, expRes, expLat);
        applyStimulus(1'b1, opv, a, b, rd);
        doneCyc  = -1;
        stallCnt = 0;
        for (int cyc = 0; cyc < 40 && doneCyc < 0; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                doneCyc = cyc;
                checkOutput({tag, "/result"}, bus.result, expRes);
                checkOutput({tag, "/rd_out"}, 32'(bus.rd_out), 32'(rd));
                checkOutput({tag, "/stall_in_done"}, 32'(bus.stall), 32'd0);
            end else if (bus.stall === 1'b1) begin
                stallCnt++;
            end
            @(posedge clk);
            #1;
            if (doneCyc >= 0) applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
            else if (cyc + 1 == glitchCyc) applyStimulus(1'b1, ~opv, ~a, b + 32'd1, ~rd);
            else if (cyc == glitchCyc) applyStimulus(1'b1, opv, a, b, rd);
        end
        bus.start = 1'b0;
        checkOutput({tag, "/done_cycle"}, 32'(doneCyc), 32'(expLat));
        checkOutput({tag, "/stall_cycles"}, 32'(stallCnt), 32'(expLat));
        @(negedge clk);
        checkOutput({tag, "/done_pulse_end"}, 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rrd;
        int          sel;
        bit          sawDone;

        $display("[TB] ex_divider bench starting");
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        bus.flush = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset/done", 32'(bus.done), 32'd0);
        checkOutput("reset/result", bus.result, 32'd0);
        checkOutput("reset/rd_out", 32'(bus.rd_out), 32'd0);
        checkOutput("reset/busy", 32'(bus.busy), 32'd0);
        checkOutput("reset/stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed operand patterns and shortcut cases.
        runOp("div_100_7",   DIV_OP_DIV,  32'd100,        32'd7,          5'd3,  -1);
        runOp("rem_100_7",   DIV_OP_REM,  32'd100,        32'd7,          5'd4,  -1);
        runOp("div_m7_2",    DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd5,  -1);
        runOp("rem_m7_2",    DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd6,  -1);
        runOp("divu_max_1",  DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd7,  -1);
        runOp("remu_max_16", DIV_OP_REMU, 32'hFFFF_FFFF,  32'h10,         5'd8,  -1);
        runOp("divu_5_0",    DIV_OP_DIVU, 32'd5,          32'd0,          5'd9,  -1);
        runOp("rem_5_0",     DIV_OP_REM,  32'd5,          32'd0,          5'd10, -1);
        runOp("div_ovf",     DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, -1);
        runOp("rem_ovf",     DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, -1);
        runOp("div_glitch",  DIV_OP_DIV,  32'd1000,       32'd7,          5'd13, 5);

        // Flush mid-CALC: back to idle with no done pulse, then a fresh op.
        sawDone = 1'b0;
        applyStimulus(1'b1, DIV_OP_DIV, 32'd1000, 32'd3, 5'd14);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) sawDone = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("flush/stall_c10", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        if (bus.done === 1'b1) sawDone = 1'b1;
        checkOutput("flush/busy_c11", 32'(bus.busy), 32'd0);
        checkOutput("flush/stall_c11", 32'(bus.stall), 32'd0);
        checkOutput("flush/no_done", 32'(sawDone), 32'd0);
        @(posedge clk);
        #1;
        runOp("flush_divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 5'd15, -1);

        // Flush together with start in IDLE: start must not be taken.
        bus.flush = 1'b1;
        applyStimulus(1'b1, DIV_OP_DIV, 32'd20, 32'd4, 5'd16);
        @(negedge clk);
        checkOutput("flush_start/stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("flush_start/busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-CALC clears outputs immediately; a fresh op then runs.
        applyStimulus(1'b1, DIV_OP_DIV, 32'd77, 32'd3, 5'd17);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid/done", 32'(bus.done), 32'd0);
        checkOutput("rst_mid/result", bus.result, 32'd0);
        checkOutput("rst_mid/rd_out", 32'(bus.rd_out), 32'd0);
        checkOutput("rst_mid/busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runOp("rst_div_50_5", DIV_OP_DIV, 32'd50, 32'd5, 5'd18, -1);

        // Random ops, biased towards shortcuts and small divisors.
        for (int n = 0; n < 16; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rrd = 5'($urandom_range(1, 31));
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = $urandom_range(1, 15);
            else if (sel == 3) rb = -($urandom_range(1, 15));
            else rb = $urandom;
            runOp("random", rop, ra, rb, rrd, -1);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/ex_divider.md
Name: ex_divider

Overview:
- Iterative radix-2 integer divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
- Consumes the forwarded operands (rs1_reg/rs2_reg) produced by the EX-stage operand-forwarding mux.
- Stalls the pipeline while computing, then returns the result and destination tag to the EX/MEM path for one cycle.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  EX holds a valid divide op with final forwarded operands
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_reg  input  XLEN  dividend (post-forwarding)
- rs2_reg  input  XLEN  divisor (post-forwarding)
- rd_in  input  5  destination register of the divide op
- flush  input  1  kill in-flight op (branch/trap redirect)
- stall  output  1  hold IF/ID/EX; combinational
- busy  output  1  state != IDLE
- done  output  1  one-cycle result-valid pulse
- result  output  XLEN  quotient or remainder; valid when done
- rd_out  output  5  destination tag; valid when done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; done=0, result=0, rd_out=0, all internal registers 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE + start + !flush: latch op and rd_in; form |rs1|, |rs2| for DIV/REM, raw operands for DIVU/REMU; record the quotient sign (rs1[XLEN-1]^rs2[XLEN-1]) and the remainder sign (rs1[XLEN-1]), signed ops only.
  - Divisor==0 or signed overflow -> DONE directly.
  - Otherwise -> CALC with count=0.
- Special cases, decided at acceptance:
  - divisor 0: quotient all-ones, remainder = rs1_reg.
  - signed ops with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- CALC: one restoring step per cycle.
  - Shift {rem,quo} left by 1; trial subtract of divisor on an XLEN+1-bit remainder.
  - If non-negative, keep the difference and set the quo LSB.
  - After step XLEN (count==XLEN-1), go to DONE.
- DONE: result is registered on entry.
  - Quotient negated if its sign is set (DIV); remainder negated if its sign is set (REM).
  - done=1 for exactly this cycle; next state IDLE.
- Latency (start accepted in cycle 0):
  - Normal ops: done in cycle XLEN+1, i.e. 33.
  - Special cases: done in cycle 1.
- stall = (state==IDLE && start && !flush) || state==CALC. stall is 0 in DONE so EX advances while done=1.
- start while busy: ignored, with no queueing. EX holds start until done by construction.
- flush: synchronous, overrides everything.
  - Any state -> IDLE next cycle; done forced 0 that cycle and after.
  - flush and start together in IDLE: start is not accepted.
- result/rd_out hold their last value after done. Consumers must qualify them with done.
- Signed arithmetic: negation is two's-complement, XLEN-bit wrap. Absolute value of 0x80000000 is the same bit pattern, treated as unsigned 2^31.

Decomposition:
- Shared package holds:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU (2'b00..2'b11).
  - State encoding ST_IDLE/ST_CALC/ST_DONE.
  - Special-result constants DIV_ZERO_Q (all-ones) and DIV_OVF_Q (MSB only).
- One sub-module: ex_div_core.
  - Unsigned restoring iteration datapath: rem/quo/divisor registers, step counter, load and step enables, last-step flag.
- The top module owns the FSM, sign handling, special cases, flush and stall.

Test Plan:
- DIV 100/7, start cycle 0 -> stall=1 cycles 0–32, done cycle 33, result=14, rd_out=rd_in; REM same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; REMU 0xFFFFFFFF/0x10 -> 0xF.
- DIVU 5/0 -> done cycle 1, result 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM same -> 0.
- Start DIV 1000/3, assert flush at cycle 10 -> IDLE at cycle 11, no done pulse, stall=0; new start at cycle 12 (DIVU 9/3) -> done at cycle 45, result 3.
- Pulse a different start/op/operands during CALC -> ignored; original op completes with its own result and rd_out.
- Drop rst_n at cycle 15 mid-CALC -> outputs 0 immediately, busy=0; after release, a fresh 50/5 DIV -> result 10 at 33 cycles.
